// File: rtl/pq_regs_pkg.sv
// Register map, bus FSM states and request decoding shared by the packet
// queue top level and its bench-visible constants.
package pq_regs_pkg;

    localparam logic [11:0] BASE_HI_DEFAULT = 12'hFE8;

    // Offsets are word indices taken from wbs_adr_i[7:2]; bits [5:4] select the group.
    localparam logic [1:0] OFF_GRP_POP     = 2'b00;
    localparam logic [5:0] OFF_STATUS      = 6'h10;
    localparam logic [1:0] OFF_GRP_LEVEL   = 2'b10;

    localparam int STATUS_NE_LSB   = 0;
    localparam int STATUS_FULL_LSB = 16;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } bus_state_e;

    typedef enum logic [1:0] {
        REQ_POP,
        REQ_STATUS,
        REQ_LEVEL,
        REQ_ERR
    } req_kind_e;

    function automatic req_kind_e decode_kind(input logic [5:0] off, input int channels);
        req_kind_e kind;
        kind = REQ_ERR;
        if (off == OFF_STATUS) begin
            kind = REQ_STATUS;
        end else if (off[5:4] == OFF_GRP_POP) begin
            if (int'(off[3:0]) < channels) kind = REQ_POP;
        end else if (off[5:4] == OFF_GRP_LEVEL) begin
            if (int'(off[3:0]) < channels) kind = REQ_LEVEL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/pq_chan_fifo.sv
// Single-channel circular FIFO of trace addresses with occupancy count;
// push is ignored when full, pop is ignored when empty.
module pq_chan_fifo #(
    parameter int DEPTH         = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ADDRESS_WIDTH-1:0]   din_i,
    output logic [ADDRESS_WIDTH-1:0]   head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/multi_packet_queue.sv
// Per-channel ready queues filled by the DMA and drained, inspected or
// discarded through a registered-response Wishbone slave.
module multi_packet_queue
    import pq_regs_pkg::*;
#(
    parameter int          CHANNELS      = 2,
    parameter int          DEPTH         = 32,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [11:0] BASE_HI       = BASE_HI_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDRESS_WIDTH-1:0]          wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]             wbs_dat_i,
    input  logic                              wbs_we_i,
    input  logic                              wbs_cyc_i,
    input  logic                              wbs_stb_i,
    output logic [DATA_WIDTH-1:0]             wbs_dat_o,
    output logic                              wbs_ack_o,
    output logic                              wbs_err_o,
    output logic                              wbs_rty_o,
    input  logic [CHANNELS-1:0]               fifo_store_packet,
    input  logic [CHANNELS*ADDRESS_WIDTH-1:0] bus_initial_trace_address,
    output logic [CHANNELS-1:0]               address_ack,
    output logic [ADDRESS_WIDTH-1:0]          discard_queue,
    output logic                              discard_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]      full, empty, nonempty, push, pop;
    logic [ADDRESS_WIDTH-1:0] head  [CHANNELS];
    logic [CW-1:0]            level [CHANNELS];

    bus_state_e               state_q, state_d;
    req_kind_e                kind_q, kind_d;
    logic [3:0]               chan_q, chan_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] discard_q, discard_d;
    logic                     discard_vld_q, discard_vld_d;

    logic                     accept;
    req_kind_e                req_kind;
    logic [DATA_WIDTH-1:0]    status;
    logic                     unused_adr;

    assign unused_adr = ^{wbs_adr_i[19:8], wbs_adr_i[1:0]};

    genvar gc;
    generate
        for (gc = 0; gc < CHANNELS; gc++) begin : g_chan
            pq_chan_fifo #(
                .DEPTH        (DEPTH),
                .ADDRESS_WIDTH(ADDRESS_WIDTH)
            ) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .push_i (push[gc]),
                .pop_i  (pop[gc]),
                .din_i  (bus_initial_trace_address[gc*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
                .head_o (head[gc]),
                .count_o(level[gc]),
                .full_o (full[gc]),
                .empty_o(empty[gc])
            );
        end
    endgenerate

    assign nonempty    = ~empty;
    assign push        = fifo_store_packet & ~full & {CHANNELS{~rst}};
    assign address_ack = push;
    assign wbs_rty_o   = 1'b0;

    assign req_kind = decode_kind(wbs_adr_i[7:2], CHANNELS);
    assign accept   = (state_q == ST_IDLE) && wbs_cyc_i && wbs_stb_i
                      && (wbs_adr_i[31:20] == BASE_HI);

    // The request is captured on acceptance so the ACK cycle acts on it even if the master drops stb.
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        chan_d        = chan_q;
        we_d          = we_q;
        discard_d     = discard_q;
        discard_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACK;
                    kind_d  = req_kind;
                    chan_d  = wbs_adr_i[5:2];
                    we_d    = wbs_we_i;
                    if (wbs_we_i && req_kind == REQ_POP) begin
                        discard_d     = ADDRESS_WIDTH'(wbs_dat_i);
                        discard_vld_d = 1'b1;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= REQ_ERR;
            chan_q        <= '0;
            we_q          <= 1'b0;
            discard_q     <= '0;
            discard_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            chan_q        <= chan_d;
            we_q          <= we_d;
            discard_q     <= discard_d;
            discard_vld_q <= discard_vld_d;
        end
    end

    assign discard_queue = discard_q;
    assign discard_valid = discard_vld_q;

    always_comb begin
        status = '0;
        status[STATUS_FULL_LSB +: CHANNELS] = full;
        status[STATUS_NE_LSB +: CHANNELS]   = nonempty;
    end

    // Response and pop are both driven from the registered ACK state only.
    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_err_o = 1'b0;
        wbs_dat_o = '0;
        pop       = '0;
        if (state_q == ST_ACK) begin
            if (kind_q == REQ_ERR) begin
                wbs_err_o = 1'b1;
            end else begin
                wbs_ack_o = 1'b1;
                if (!we_q) begin
                    case (kind_q)
                        REQ_STATUS: wbs_dat_o = status;
                        REQ_POP: begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (chan_q == c[3:0]) begin
                                    if (nonempty[c]) begin
                                        wbs_dat_o = DATA_WIDTH'(head[c]);
                                        pop[c]    = 1'b1;
                                    end else begin
                                        wbs_dat_o = '1;
                                    end
                                end
                            end
                        end
                        REQ_LEVEL: begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (chan_q == c[3:0]) wbs_dat_o = DATA_WIDTH'(level[c]);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_packet_queue.sv
// Bench for multi_packet_queue: register-map vector table with a per-channel
// address scoreboard, plus sequences for full, wrap, discard and reset cases.
module tb_multi_packet_queue;

    localparam int CH    = 2;
    localparam int DEPTH = 32;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    wbs_adr;
    logic [DW-1:0]    wbs_dat_w;
    logic             wbs_we, wbs_cyc, wbs_stb;
    logic [DW-1:0]    wbs_dat_o;
    logic             wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [CH-1:0]    store;
    logic [CH*AW-1:0] trace;
    logic [CH-1:0]    address_ack;
    logic [AW-1:0]    discard_queue;
    logic             discard_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb [CH][$];
    logic        dv_seen;
    logic [31:0] dq_seen;

    multi_packet_queue #(
        .CHANNELS(CH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_HI(12'hFE8)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .wbs_adr_i                (wbs_adr),
        .wbs_dat_i                (wbs_dat_w),
        .wbs_we_i                 (wbs_we),
        .wbs_cyc_i                (wbs_cyc),
        .wbs_stb_i                (wbs_stb),
        .wbs_dat_o                (wbs_dat_o),
        .wbs_ack_o                (wbs_ack_o),
        .wbs_err_o                (wbs_err_o),
        .wbs_rty_o                (wbs_rty_o),
        .fifo_store_packet        (store),
        .bus_initial_trace_address(trace),
        .address_ack              (address_ack),
        .discard_queue            (discard_queue),
        .discard_valid            (discard_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_push;
        bit          we;
        int          ch;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          exp_ack;
        bit          exp_err;
        bit          sb_pop;
        logic [31:0] exp_dat;
        string       name;
    } vec_t;

    function automatic vec_t mk(bit is_push, bit we, int ch, logic [31:0] adr, logic [31:0] dat,
                                bit exp_ack, bit exp_err, bit sb_pop, logic [31:0] exp_dat, string name);
        vec_t v;
        v.is_push = is_push; v.we = we; v.ch = ch; v.adr = adr; v.dat = dat;
        v.exp_ack = exp_ack; v.exp_err = exp_err; v.sb_pop = sb_pop; v.exp_dat = exp_dat; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is always #1 after a rising edge on entry and on return.
    task automatic do_push(input int ch, input logic [31:0] a, input string name);
        bit exp;
        exp = (sb[ch].size() < DEPTH);
        store[ch] = 1'b1;
        trace[ch*AW +: AW] = a;
        #1 chk(name, 32'(address_ack[ch]), 32'(exp));
        @(posedge clk); #1;
        store[ch] = 1'b0;
        if (exp) sb[ch].push_back(a);
    endtask

    task automatic bus(input logic [31:0] adr, input bit we, input logic [31:0] d,
                       output logic [31:0] rd, output bit ack, output bit err, output bit early);
        wbs_adr = adr; wbs_we = we; wbs_dat_w = d; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        #1 early = wbs_ack_o | wbs_err_o;
        @(posedge clk); #1;
        ack = wbs_ack_o; err = wbs_err_o; rd = wbs_dat_o;
        dv_seen = discard_valid; dq_seen = discard_queue;
        @(posedge clk); #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        bit ack, err, early;
        bus(adr, 1'b0, 32'h0, rd, ack, err, early);
        chk({name, "_ack"}, 32'(ack), 32'd1);
        chk({name, "_dat"}, rd, exp);
    endtask

    function automatic logic [31:0] sb_pop_exp(input int ch);
        if (sb[ch].size() > 0) return sb[ch].pop_front();
        return 32'hFFFF_FFFF;
    endfunction

    vec_t tbl [16];

    initial begin
        logic [31:0] rd, exp;
        bit ack, err, early;

        rst = 1'b1; wbs_adr = '0; wbs_dat_w = '0; wbs_we = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
        store = '1; trace = '0;

        tbl[0]  = mk(1, 0, 0, 32'h0,         32'h1000,  1, 0, 0, 32'h0,         "push0_a");
        tbl[1]  = mk(1, 0, 0, 32'h0,         32'h1004,  1, 0, 0, 32'h0,         "push0_b");
        tbl[2]  = mk(0, 0, 0, 32'hFE800040,  32'h0,     1, 0, 0, 32'h0000_0001, "status_ne0");
        tbl[3]  = mk(0, 0, 0, 32'hFE800080,  32'h0,     1, 0, 0, 32'd2,         "level0_2");
        tbl[4]  = mk(0, 0, 1, 32'hFE800084,  32'h0,     1, 0, 0, 32'd0,         "level1_0");
        tbl[5]  = mk(0, 0, 0, 32'hFE800000,  32'h0,     1, 0, 1, 32'h0,         "pop0_first");
        tbl[6]  = mk(0, 0, 0, 32'hFE800000,  32'h0,     1, 0, 1, 32'h0,         "pop0_second");
        tbl[7]  = mk(0, 0, 0, 32'hFE800000,  32'h0,     1, 0, 1, 32'h0,         "pop0_empty");
        tbl[8]  = mk(0, 0, 0, 32'hFE800020,  32'h0,     0, 1, 0, 32'h0,         "err_ch8");
        tbl[9]  = mk(0, 0, 0, 32'hFE800044,  32'h0,     0, 1, 0, 32'h0,         "err_unmapped");
        tbl[10] = mk(0, 0, 0, 32'hFE800088,  32'h0,     0, 1, 0, 32'h0,         "err_level_ch2");
        tbl[11] = mk(0, 0, 0, 32'h12300000,  32'h0,     0, 0, 0, 32'h0,         "nomatch");
        tbl[12] = mk(0, 1, 0, 32'hFE800040,  32'h5,     1, 0, 0, 32'h0,         "wr_status");
        tbl[13] = mk(0, 0, 0, 32'hFE800040,  32'h0,     1, 0, 0, 32'h0,         "status_zero");
        tbl[14] = mk(1, 0, 1, 32'h0,         32'h2000,  1, 0, 0, 32'h0,         "push1_a");
        tbl[15] = mk(0, 0, 1, 32'hFE800004,  32'h0,     1, 0, 1, 32'h0,         "pop1");

        // reset state, with pushes requested while rst is high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address_ack", 32'(address_ack), 32'h0);
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_err", 32'(wbs_err_o), 32'h0);
        chk("rst_rty", 32'(wbs_rty_o), 32'h0);
        chk("rst_discard_q", discard_queue, 32'h0);
        chk("rst_discard_v", 32'(discard_valid), 32'h0);
        rst = 1'b0; store = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_push) begin
                do_push(tbl[i].ch, tbl[i].dat, tbl[i].name);
            end else begin
                exp = tbl[i].exp_dat;
                if (tbl[i].sb_pop) exp = sb_pop_exp(tbl[i].ch);
                bus(tbl[i].adr, tbl[i].we, tbl[i].dat, rd, ack, err, early);
                chk({tbl[i].name, "_early"}, 32'(early), 32'h0);
                chk({tbl[i].name, "_ack"}, 32'(ack), 32'(tbl[i].exp_ack));
                chk({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].exp_err));
                chk({tbl[i].name, "_dat"}, rd, exp);
            end
        end

        // fill channel 1, 33rd push must be held
        for (int i = 0; i < DEPTH; i++) do_push(1, 32'h3000 + 32'(4 * i), "fill1");
        do_push(1, 32'h3FFC, "fill1_held");
        rd_chk(32'hFE800040, 32'h0002_0002, "status_full1");
        rd_chk(32'hFE800084, 32'd32, "level1_full");
        for (int i = 0; i < DEPTH; i++) rd_chk(32'hFE800004, sb_pop_exp(1), "drain1");
        rd_chk(32'hFE800004, 32'hFFFF_FFFF, "drain1_empty");

        // channel 0 at level 5, 40 simultaneous push+pop cycles across pointer wrap
        for (int i = 0; i < 5; i++) do_push(0, 32'h4000 + 32'(4 * i), "pre5");
        for (int i = 0; i < 40; i++) begin
            wbs_adr = 32'hFE800000; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
            @(posedge clk); #1;
            chk("simul_ack", 32'(wbs_ack_o), 32'h1);
            chk("simul_dat", wbs_dat_o, sb[0][0]);
            store[0] = 1'b1; trace[0 +: AW] = 32'h5000 + 32'(4 * i);
            #1 chk("simul_address_ack", 32'(address_ack[0]), 32'h1);
            @(posedge clk); #1;
            store[0] = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
            void'(sb[0].pop_front());
            sb[0].push_back(32'h5000 + 32'(4 * i));
        end
        rd_chk(32'hFE800080, 32'd5, "simul_level");
        for (int i = 0; i < 5; i++) rd_chk(32'hFE800000, sb_pop_exp(0), "simul_drain");

        // pop of empty channel coinciding with a push: no bypass
        wbs_adr = 32'hFE800004; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        @(posedge clk); #1;
        chk("nobypass_dat", wbs_dat_o, 32'hFFFF_FFFF);
        store[1] = 1'b1; trace[AW +: AW] = 32'h7000;
        @(posedge clk); #1;
        store[1] = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
        sb[1].push_back(32'h7000);
        rd_chk(32'hFE800084, 32'd1, "nobypass_level");
        rd_chk(32'hFE800004, sb_pop_exp(1), "nobypass_pop");

        // discard write
        do_push(0, 32'h8000, "disc_pre_a");
        do_push(0, 32'h8004, "disc_pre_b");
        bus(32'hFE800004, 1'b1, 32'hDEADBEEF, rd, ack, err, early);
        chk("disc_ack", 32'(ack), 32'h1);
        chk("disc_valid_ack_cycle", 32'(dv_seen), 32'h1);
        chk("disc_queue_ack_cycle", dq_seen, 32'hDEADBEEF);
        chk("disc_valid_after", 32'(discard_valid), 32'h0);
        chk("disc_queue_after", discard_queue, 32'hDEADBEEF);
        rd_chk(32'hFE800080, 32'd2, "disc_level0");
        rd_chk(32'hFE800084, 32'd0, "disc_level1");

        // reset during the IDLE->ACK transition of a pop at level 3
        do_push(0, 32'h800C, "rstmid_pre");
        rd_chk(32'hFE800080, 32'd3, "rstmid_level3");
        wbs_adr = 32'hFE800000; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ack", 32'(wbs_ack_o), 32'h0);
        chk("rstmid_err", 32'(wbs_err_o), 32'h0);
        rst = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ack_later", 32'(wbs_ack_o), 32'h0);
        sb[0].delete(); sb[1].delete();
        rd_chk(32'hFE800040, 32'h0, "rstmid_status");
        rd_chk(32'hFE800080, 32'd0, "rstmid_level0");
        rd_chk(32'hFE800084, 32'd0, "rstmid_level1");
        chk("rstmid_discard_q", discard_queue, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_packet_queue.md
MULTI_PACKET_QUEUE -- requirements
Module: multi_packet_queue

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent ready queues (legal 1..8).
REQ-002 SHALL have parameter DEPTH, default 32, entries per queue (power of two, >= 2).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, trace address width; DATA_WIDTH, default 32, bus data width.
REQ-004 SHALL have parameter BASE_HI, default 12'hFE8, match value for wbs_adr_i[31:20].
REQ-005 SHALL have ports clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have wbs_adr_i in ADDRESS_WIDTH, wbs_dat_i in DATA_WIDTH, wbs_we_i/wbs_cyc_i/wbs_stb_i in 1 each, Wishbone slave request.
REQ-007 SHALL have wbs_dat_o out DATA_WIDTH, wbs_ack_o/wbs_err_o/wbs_rty_o out 1 each, Wishbone slave response.
REQ-008 SHALL have fifo_store_packet in CHANNELS, per-channel push request from the DMA.
REQ-009 SHALL have bus_initial_trace_address in CHANNELS*ADDRESS_WIDTH, channel c at bits [c*AW +: AW].
REQ-010 SHALL have address_ack out CHANNELS, per-channel push accepted.
REQ-011 SHALL have discard_queue out ADDRESS_WIDTH, last discarded address; discard_valid out 1, one-cycle strobe.

Function
REQ-012 SHALL accept a push on channel c in any cycle fifo_store_packet[c]=1 and queue c not full; address_ack[c] combinational = fifo_store_packet[c] & ~full[c].
REQ-013 SHALL hold a push on a full queue (address_ack[c]=0, no data lost, no overwrite); DMA retries.
REQ-014 SHALL decode only when wbs_adr_i[31:20]==BASE_HI; otherwise no ack/err is ever raised.
REQ-015 SHALL use offset wbs_adr_i[7:2]: 0x00+4c pop/discard channel c; 0x40 status; 0x80+4c level of channel c; all other offsets unmapped.
REQ-016 SHALL implement a two-state bus FSM IDLE->ACK when cyc&stb&match in IDLE, ACK->IDLE unconditionally; ack/err asserted only in ACK, one cycle, so responses are registered and never back-to-back.
REQ-017 SHALL, on read of 0x00+4c: if queue nonempty return head and pop it in the ACK cycle; if empty return all-ones and not pop.
REQ-018 SHALL, on write of 0x00+4c: load discard_queue with wbs_dat_i and pulse discard_valid in the ACK cycle; queues unchanged.
REQ-019 SHALL return status = {full[CHANNELS-1:0] at bits 16+, nonempty[CHANNELS-1:0] at bits 0+}, other bits zero; writes to 0x40 and 0x80+ ignored but acked.
REQ-020 SHALL return level of channel c (0..DEPTH) zero-extended on read of 0x80+4c.
REQ-021 SHALL raise wbs_err_o instead of ack for unmapped offsets or channel index >= CHANNELS, with wbs_dat_o=0; no side effect.
REQ-022 SHALL handle simultaneous push and pop on one channel: both occur, level unchanged, wrap-around of pointers transparent.
REQ-023 SHALL not bypass: a pop of an empty queue coinciding with a push returns all-ones; pushed entry remains.
REQ-024 SHALL tie wbs_rty_o to 0; wbs_dat_o SHALL be 0 outside ACK.
REQ-025 SHALL drop a cycle if cyc/stb is deasserted in ACK: FSM still returns to IDLE, pop already committed.

Reset
REQ-026 SHALL on rst: empty all queues (levels 0), FSM IDLE, wbs_ack_o=0, wbs_err_o=0, discard_queue=0, discard_valid=0.
REQ-027 SHALL on rst mid-transaction abort it without ack and without popping; address_ack SHALL be 0 while rst=1.

Structure
REQ-028 SHALL place BASE_HI default, register offsets and status bit positions in shared package pq_regs_pkg.
REQ-029 SHALL instantiate one sub-module pq_chan_fifo (DEPTH, ADDRESS_WIDTH, count output) per channel via generate.

Verification
REQ-030 Push 0x1000,0x1004 on ch0, read 0xFE800000 twice, then third read -> 0x1000, 0x1004, 0xFFFFFFFF; each ack one cycle after stb.
REQ-031 Push 32 entries to ch1 (DEPTH=32), hold 33rd -> address_ack[1]=0, status bit17=1, level 0xFE800084 reads 32.
REQ-032 Ch0 level 5, simultaneous push and pop -> read returns head, level stays 5; repeat 40 times across wrap, order preserved.
REQ-033 Write 0xDEADBEEF to 0xFE800004 -> discard_queue=0xDEADBEEF, discard_valid high exactly one cycle, levels unchanged.
REQ-034 Read 0xFE800020 with CHANNELS=2 -> wbs_err_o one cycle, no ack; read 0x12300000 -> no response.
REQ-035 Assert rst in IDLE->ACK transition of a pop with level 3 -> no ack, all levels 0, status reads 0 after reset.
